// File: rtl/tag_ram_ctrl_if.sv
// Bus between the cache control logic, the tag RAM controller and the tag RAM.
// The slave modport is the controller side; master is cache control plus the RAM.
interface tag_ram_ctrl_if #(
   parameter int unsigned AWIDTH = 3,
   parameter int unsigned TWIDTH = 13,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned DWIDTH = TWIDTH + 1;

   logic                      flush_req;
   logic                      fill_req;
   logic [TWIDTH+AWIDTH-1:0]  fill_addr;
   logic                      fill_done;
   logic                      lookup_req;
   logic [TWIDTH+AWIDTH-1:0]  lookup_addr;
   logic                      lookup_ready;
   logic                      resp_valid;
   logic                      resp_hit;
   logic                      busy;
   logic [CNT_W-1:0]          hit_count;
   logic [CNT_W-1:0]          miss_count;
   logic [AWIDTH-1:0]         ram_addr;
   logic [DWIDTH-1:0]         ram_din;
   logic                      ram_we;
   logic [DWIDTH-1:0]         ram_dout;

   modport slave (
      input  flush_req, fill_req, fill_addr, lookup_req, lookup_addr, ram_dout,
      output fill_done, lookup_ready, resp_valid, resp_hit, busy,
             hit_count, miss_count, ram_addr, ram_din, ram_we
   );

   modport master (
      output flush_req, fill_req, fill_addr, lookup_req, lookup_addr, ram_dout,
      input  fill_done, lookup_ready, resp_valid, resp_hit, busy,
             hit_count, miss_count, ram_addr, ram_din, ram_we
   );
endinterface

// File: rtl/tag_ram_ctrl.sv
// Tag RAM sequencer for a direct-mapped cache: flush, fill and lookup share the
// single RAM port; lookups return hit/miss and update saturating statistics.
module tag_ram_ctrl #(
   parameter int unsigned AWIDTH = 3,
   parameter int unsigned TWIDTH = 13,
   parameter int unsigned CNT_W  = 16
) (
   input logic           clock,
   input logic           reset,
   tag_ram_ctrl_if.slave bus
);
   localparam int unsigned DEPTH  = 1 << AWIDTH;
   localparam int unsigned DWIDTH = TWIDTH + 1;

   localparam logic [2:0] S_FLUSH = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_RD    = 3'd2;
   localparam logic [2:0] S_CMP   = 3'd3;
   localparam logic [2:0] S_WR    = 3'd4;

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic [AWIDTH-1:0] r_cnt;
   logic [AWIDTH-1:0] r_idx;
   logic [TWIDTH-1:0] r_tag;
   logic              r_resp_valid;
   logic              r_resp_hit;
   logic              r_fill_done;
   logic [CNT_W-1:0]  r_hit_cnt;
   logic [CNT_W-1:0]  r_miss_cnt;
   logic              w_hit;

   assign w_hit = bus.ram_dout[DWIDTH-1] && (bus.ram_dout[TWIDTH-1:0] == r_tag);

   // Next-state decode; IDLE priority is flush > fill > lookup
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FLUSH: if (r_cnt == AWIDTH'(DEPTH - 1)) w_state_nxt = S_IDLE;
         S_IDLE: begin
            if (bus.flush_req)       w_state_nxt = S_FLUSH;
            else if (bus.fill_req)   w_state_nxt = S_WR;
            else if (bus.lookup_req) w_state_nxt = S_RD;
         end
         S_WR:    w_state_nxt = S_IDLE;
         S_RD:    w_state_nxt = S_CMP;
         S_CMP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_FLUSH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_FLUSH;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_tag        <= '0;
         r_resp_valid <= 1'b0;
         r_resp_hit   <= 1'b0;
         r_fill_done  <= 1'b0;
         r_hit_cnt    <= '0;
         r_miss_cnt   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_resp_valid <= 1'b0;
         r_fill_done  <= 1'b0;
         case (r_state)
            S_FLUSH: r_cnt <= r_cnt + AWIDTH'(1);
            S_IDLE: begin
               if (bus.flush_req)       r_cnt <= '0;
               else if (bus.fill_req)   {r_tag, r_idx} <= bus.fill_addr;
               else if (bus.lookup_req) {r_tag, r_idx} <= bus.lookup_addr;
            end
            S_WR: r_fill_done <= 1'b1;
            S_CMP: begin
               r_resp_valid <= 1'b1;
               r_resp_hit   <= w_hit;
               // Statistics stick at all-ones instead of wrapping
               if (w_hit) begin
                  if (r_hit_cnt != {CNT_W{1'b1}}) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
               end else begin
                  if (r_miss_cnt != {CNT_W{1'b1}}) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ram_we       = (r_state == S_FLUSH) || (r_state == S_WR);
   assign bus.ram_addr     = (r_state == S_FLUSH) ? r_cnt : r_idx;
   assign bus.ram_din      = (r_state == S_WR) ? {1'b1, r_tag} : '0;
   assign bus.lookup_ready = (r_state == S_IDLE) && !bus.flush_req && !bus.fill_req;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.resp_valid   = r_resp_valid;
   assign bus.resp_hit     = r_resp_hit;
   assign bus.fill_done    = r_fill_done;
   assign bus.hit_count    = r_hit_cnt;
   assign bus.miss_count   = r_miss_cnt;
endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Directed bench for tag_ram_ctrl with a behavioural synchronous-read tag RAM.
// CNT_W is 2 so that counter saturation is reachable in a short run.
module tb_tag_ram_ctrl;
   localparam int unsigned AWIDTH = 3;
   localparam int unsigned TWIDTH = 13;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned DWIDTH = TWIDTH + 1;

   logic clock;
   logic reset;
   int   n_chk;
   int   n_pass;
   int   n_fail;

   tag_ram_ctrl_if #(.AWIDTH(AWIDTH), .TWIDTH(TWIDTH), .CNT_W(CNT_W)) bus ();

   tag_ram_ctrl #(.AWIDTH(AWIDTH), .TWIDTH(TWIDTH), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [DWIDTH-1:0] mem [1 << AWIDTH];

   always_ff @(posedge clock) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept a lookup in IDLE, then step through RD and CMP to the result cycle
   task automatic do_lookup(input logic [TWIDTH-1:0] tag, input logic [AWIDTH-1:0] idx,
                            input logic exp_hit, input logic [CNT_W-1:0] exp_hits,
                            input logic [CNT_W-1:0] exp_miss);
      bus.lookup_req  = 1'b1;
      bus.lookup_addr = {tag, idx};
      #1;
      chk("lkp_ready", 32'(bus.lookup_ready), 32'd1);
      tick();
      bus.lookup_req = 1'b0;
      chk("rd_addr", 32'(bus.ram_addr), 32'(idx));
      chk("rd_we", 32'(bus.ram_we), 32'd0);
      tick();
      chk("cmp_no_resp", 32'(bus.resp_valid), 32'd0);
      tick();
      chk("resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("resp_hit", 32'(bus.resp_hit), 32'(exp_hit));
      chk("hit_count", 32'(bus.hit_count), 32'(exp_hits));
      chk("miss_count", 32'(bus.miss_count), 32'(exp_miss));
   endtask

   task automatic flush_walk(input string tag);
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_we"}, 32'(bus.ram_we), 32'd1);
         chk({tag, "_addr"}, 32'(bus.ram_addr), 32'(i));
         chk({tag, "_din"}, 32'(bus.ram_din), 32'd0);
         chk({tag, "_rdy"}, 32'(bus.lookup_ready), 32'd0);
         tick();
      end
      chk({tag, "_done_rdy"}, 32'(bus.lookup_ready), 32'd1);
      chk({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_fail = 0;
      reset = 1'b1;
      bus.flush_req = 1'b0; bus.fill_req = 1'b0; bus.lookup_req = 1'b0;
      bus.fill_addr = '0;   bus.lookup_addr = '0;

      // Reset and power-on flush
      tick(); tick();
      chk("rst_busy", 32'(bus.busy), 32'd1);
      chk("rst_ready", 32'(bus.lookup_ready), 32'd0);
      chk("rst_resp", 32'(bus.resp_valid), 32'd0);
      chk("rst_fdone", 32'(bus.fill_done), 32'd0);
      chk("rst_hits", 32'(bus.hit_count), 32'd0);
      chk("rst_miss", 32'(bus.miss_count), 32'd0);
      reset = 1'b0;
      flush_walk("pflush");

      // Miss on an empty cache
      do_lookup(13'h0A5, 3'd3, 1'b0, 2'd0, 2'd1);
      tick();
      chk("resp_pulse", 32'(bus.resp_valid), 32'd0);

      // Fill then hit
      bus.fill_req = 1'b1; bus.fill_addr = {13'h0A5, 3'd3};
      #1;
      chk("fill_ready", 32'(bus.lookup_ready), 32'd0);
      tick();
      bus.fill_req = 1'b0;
      chk("wr_we", 32'(bus.ram_we), 32'd1);
      chk("wr_addr", 32'(bus.ram_addr), 32'd3);
      chk("wr_din", 32'(bus.ram_din), 32'h20A5);
      chk("wr_nodone", 32'(bus.fill_done), 32'd0);
      tick();
      chk("fill_done", 32'(bus.fill_done), 32'd1);
      do_lookup(13'h0A5, 3'd3, 1'b1, 2'd1, 2'd1);

      // Tag mismatch at the same index
      tick();
      do_lookup(13'h0A6, 3'd3, 1'b0, 2'd1, 2'd2);

      // Fill and lookup together: fill wins, lookup then sees the new tag
      tick();
      bus.fill_req = 1'b1;   bus.fill_addr   = {13'h0A6, 3'd3};
      bus.lookup_req = 1'b1; bus.lookup_addr = {13'h0A6, 3'd3};
      #1;
      chk("sim_ready", 32'(bus.lookup_ready), 32'd0);
      tick();
      bus.fill_req = 1'b0;
      chk("sim_wr_we", 32'(bus.ram_we), 32'd1);
      chk("sim_wr_din", 32'(bus.ram_din), 32'h20A6);
      tick();
      chk("sim_fdone", 32'(bus.fill_done), 32'd1);
      do_lookup(13'h0A6, 3'd3, 1'b1, 2'd2, 2'd2);

      // Explicit flush, then the same lookup misses
      tick();
      bus.flush_req = 1'b1;
      #1;
      chk("fl_ready", 32'(bus.lookup_ready), 32'd0);
      tick();
      bus.flush_req = 1'b0;
      flush_walk("xflush");
      do_lookup(13'h0A6, 3'd3, 1'b0, 2'd2, 2'd3);

      // Reset in the middle of a flush restarts it and clears statistics
      tick();
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      tick(); tick(); tick(); tick();
      chk("mid_addr", 32'(bus.ram_addr), 32'd4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst_hits", 32'(bus.hit_count), 32'd0);
      chk("mrst_miss", 32'(bus.miss_count), 32'd0);
      flush_walk("rflush");

      // Miss counter saturates at 3
      for (int k = 1; k <= 5; k++) begin
         do_lookup(13'h0A5, 3'd3, 1'b0, 2'd0, (k > 3) ? 2'd3 : CNT_W'(k));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
